control_unit: RTL and testbench

- Instruction decoder for the RV32IM pipelined CPU, located in the ID stage.
- Maps one 32-bit instruction to the datapath control bundle: ALU op, register-file write, memory read/write, branch/jump, immediate format, operand muxes and write-back select.
- Decode is purely combinational.
- Clock port exists only for pipeline interface uniformity.

---
 rtl/rv32im_pkg.sv | 75 +++++++
 rtl/control_unit_alu_op_decoder.sv | 49 ++++
 rtl/control_unit.sv | 119 +++++++++++
 tb/tb_control_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rv32im_pkg.sv
// Shared RV32IM decode constants: opcodes, ALU operation codes, immediate formats,
// write-back selects and the control bundle produced by the ID-stage decoder.
package rv32im_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;

    // Jumps reuse the branch unit with an always-taken condition.
    localparam logic [2:0] BR_UNCOND = 3'b010;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'b00000,
        ALU_SLL    = 5'b00001,
        ALU_SLT    = 5'b00010,
        ALU_SLTU   = 5'b00011,
        ALU_XOR    = 5'b00100,
        ALU_SRL    = 5'b00101,
        ALU_OR     = 5'b00110,
        ALU_AND    = 5'b00111,
        ALU_SUB    = 5'b01000,
        ALU_SRA    = 5'b01101,
        ALU_FWD    = 5'b01111,
        ALU_MUL    = 5'b10000,
        ALU_MULH   = 5'b10001,
        ALU_MULHSU = 5'b10010,
        ALU_MULHU  = 5'b10011,
        ALU_DIV    = 5'b10100,
        ALU_DIVU   = 5'b10101,
        ALU_REM    = 5'b10110,
        ALU_REMU   = 5'b10111
    } alu_op_e;

    typedef enum logic [3:0] {
        IMM_NONE = 4'b0000,
        IMM_I    = 4'b0001,
        IMM_S    = 4'b0010,
        IMM_B    = 4'b0011,
        IMM_U    = 4'b0100,
        IMM_J    = 4'b0101
    } imm_fmt_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    typedef struct packed {
        alu_op_e    alu;
        logic       reg_write;
        logic [2:0] mem_write;
        logic [3:0] mem_read;
        logic [3:0] branch;
        imm_fmt_e   imm;
        logic       op1_pc;
        logic       op2_imm;
        wb_sel_e    wb_sel;
    } ctrl_t;

endpackage

// File: rtl/control_unit_alu_op_decoder.sv
// ALU operation selection from opcode/funct fields; also flags encodings
// that have no legal meaning so the top can squash them into a bubble.
module alu_op_decoder
    import rv32im_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output alu_op_e    alu_op_o,
    output logic       legal_o
);

    always_comb begin
        alu_op_o = ALU_ADD;
        legal_o  = 1'b1;
        case (opcode_i)
            OPC_OP: begin
                case (funct7_i)
                    FUNCT7_BASE: alu_op_o = alu_op_e'({2'b00, funct3_i});
                    FUNCT7_MEXT: alu_op_o = alu_op_e'({2'b10, funct3_i});
                    FUNCT7_ALT: begin
                        if (funct3_i == FUNCT3_ADD_SUB) begin
                            alu_op_o = ALU_SUB;
                        end else if (funct3_i == FUNCT3_SRL_SRA) begin
                            alu_op_o = ALU_SRA;
                        end else begin
                            legal_o = 1'b0;
                        end
                    end
                    default: legal_o = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                // Only instruction bit 30 distinguishes SRAI from SRLI.
                if (funct3_i == FUNCT3_SRL_SRA && funct7_i[5]) begin
                    alu_op_o = ALU_SRA;
                end else begin
                    alu_op_o = alu_op_e'({2'b00, funct3_i});
                end
            end
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_AUIPC: begin
                alu_op_o = ALU_ADD;
            end
            OPC_LUI: alu_op_o = ALU_FWD;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// ID-stage RV32IM decoder: purely combinational instruction -> control bundle.
// Illegal/unsupported words and RESET both yield an all-zero bubble.
module control_unit
    import rv32im_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    output logic [4:0]  alu_signal,
    output logic        reg_file_write,
    output logic [2:0]  main_mem_write,
    output logic [3:0]  main_mem_read,
    output logic [3:0]  branch_control,
    output logic [3:0]  immediate_select,
    output logic        oparand_1_select,
    output logic        oparand_2_select,
    output logic [1:0]  reg_write_select
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    alu_op_e    alu_op;
    logic       alu_legal;
    ctrl_t      ctrl;

    assign opcode = INSTRUCTION[6:0];
    assign funct3 = INSTRUCTION[14:12];
    assign funct7 = INSTRUCTION[31:25];

    // Register specifiers are consumed by the register file, not by decode.
    logic unused_bits;
    assign unused_bits = ^{CLK, INSTRUCTION[24:15], INSTRUCTION[11:7]};

    alu_op_decoder u_alu_op_decoder (
        .opcode_i (opcode),
        .funct3_i (funct3),
        .funct7_i (funct7),
        .alu_op_o (alu_op),
        .legal_o  (alu_legal)
    );

    always_comb begin
        ctrl     = '0;
        ctrl.alu = alu_op;
        case (opcode)
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_ALU;
            end
            OPC_OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.imm       = IMM_I;
                ctrl.op2_imm   = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = {1'b1, funct3};
                ctrl.imm       = IMM_I;
                ctrl.op2_imm   = 1'b1;
                ctrl.wb_sel    = WB_MEM;
            end
            OPC_STORE: begin
                ctrl.mem_write = {1'b1, funct3[1:0]};
                ctrl.imm       = IMM_S;
                ctrl.op2_imm   = 1'b1;
            end
            OPC_BRANCH: begin
                // ALU forms the target PC + imm; the branch unit compares rs1/rs2.
                ctrl.branch  = {1'b1, funct3};
                ctrl.imm     = IMM_B;
                ctrl.op1_pc  = 1'b1;
                ctrl.op2_imm = 1'b1;
            end
            OPC_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.branch    = {1'b1, BR_UNCOND};
                ctrl.imm       = IMM_J;
                ctrl.op1_pc    = 1'b1;
                ctrl.op2_imm   = 1'b1;
                ctrl.wb_sel    = WB_PC4;
            end
            OPC_JALR: begin
                ctrl.reg_write = 1'b1;
                ctrl.branch    = {1'b1, BR_UNCOND};
                ctrl.imm       = IMM_I;
                ctrl.op2_imm   = 1'b1;
                ctrl.wb_sel    = WB_PC4;
            end
            OPC_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.imm       = IMM_U;
                ctrl.op2_imm   = 1'b1;
                ctrl.wb_sel    = WB_ALU;
            end
            OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.imm       = IMM_U;
                ctrl.op1_pc    = 1'b1;
                ctrl.op2_imm   = 1'b1;
            end
            default: ;
        endcase
        if (RESET || !alu_legal) begin
            ctrl = '0;
        end
    end

    assign alu_signal       = ctrl.alu;
    assign reg_file_write   = ctrl.reg_write;
    assign main_mem_write   = ctrl.mem_write;
    assign main_mem_read    = ctrl.mem_read;
    assign branch_control   = ctrl.branch;
    assign immediate_select = ctrl.imm;
    assign oparand_1_select = ctrl.op1_pc;
    assign oparand_2_select = ctrl.op2_imm;
    assign reg_write_select = ctrl.wb_sel;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboarded bench for control_unit: directed test-plan words, asynchronous RESET
// behaviour, then randomized instructions against a rule-level reference model.
module tb_control_unit;

    logic        CLK;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic [4:0]  alu_signal;
    logic        reg_file_write;
    logic [2:0]  main_mem_write;
    logic [3:0]  main_mem_read;
    logic [3:0]  branch_control;
    logic [3:0]  immediate_select;
    logic        oparand_1_select;
    logic        oparand_2_select;
    logic [1:0]  reg_write_select;

    localparam int W = 25;

    logic [W-1:0]  exp_q[$];
    logic [31:0]   ins_q[$];
    logic          sample_tick;
    int            checks;
    int            errors;

    control_unit dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .INSTRUCTION      (INSTRUCTION),
        .alu_signal       (alu_signal),
        .reg_file_write   (reg_file_write),
        .main_mem_write   (main_mem_write),
        .main_mem_read    (main_mem_read),
        .branch_control   (branch_control),
        .immediate_select (immediate_select),
        .oparand_1_select (oparand_1_select),
        .oparand_2_select (oparand_2_select),
        .reg_write_select (reg_write_select)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [W-1:0] pack(input int alu, input int rfw, input int memw,
                                          input int memr, input int br, input int imm,
                                          input int op1, input int op2, input int wsel);
        logic [W-1:0] v;
        v = {alu[4:0], rfw[0], memw[2:0], memr[3:0], br[3:0], imm[3:0], op1[0], op2[0], wsel[1:0]};
        return v;
    endfunction

    // Reference model, straight from the instruction-set decode rules.
    function automatic logic [W-1:0] model(input logic [31:0] ins, input logic rst);
        int op, f3, f7;
        int alu, rfw, memw, memr, br, imm, op1, op2, wsel;
        bit ok;
        op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
        alu = 0; rfw = 0; memw = 0; memr = 0; br = 0; imm = 0; op1 = 0; op2 = 0; wsel = 0;
        ok = 1;
        case (op)
            'h33: begin
                rfw = 1;
                if (f7 == 0) alu = f3;
                else if (f7 == 1) alu = 16 + f3;
                else if (f7 == 'h20 && f3 == 0) alu = 8;
                else if (f7 == 'h20 && f3 == 5) alu = 13;
                else ok = 0;
            end
            'h13: begin
                alu = (f3 == 5 && ins[30]) ? 13 : f3;
                imm = 1; op2 = 1; rfw = 1;
            end
            'h03: begin memr = 8 + f3; imm = 1; op2 = 1; rfw = 1; wsel = 1; end
            'h23: begin memw = 4 + (f3 % 4); imm = 2; op2 = 1; end
            'h63: begin br = 8 + f3; imm = 3; op1 = 1; op2 = 1; end
            'h6f: begin br = 10; imm = 5; op1 = 1; op2 = 1; rfw = 1; wsel = 2; end
            'h67: begin br = 10; imm = 1; op2 = 1; rfw = 1; wsel = 2; end
            'h37: begin alu = 15; imm = 4; op2 = 1; rfw = 1; end
            'h17: begin imm = 4; op1 = 1; op2 = 1; rfw = 1; end
            default: ok = 0;
        endcase
        if (rst || !ok) return '0;
        return pack(alu, rfw, memw, memr, br, imm, op1, op2, wsel);
    endfunction

    // driver: change inputs between clock edges, queue the expectation, then ask for a sample
    task automatic drive(input logic [31:0] ins, input logic rst, input logic [W-1:0] exp,
                         input bit at_negedge);
        if (at_negedge) @(negedge CLK);
        INSTRUCTION = ins;
        RESET       = rst;
        exp_q.push_back(exp);
        ins_q.push_back(ins);
        #1 sample_tick = 1'b1;
        #1 sample_tick = 1'b0;
    endtask

    // monitor / scoreboard
    initial begin
        logic [W-1:0] act, exp;
        logic [31:0]  ins;
        forever begin
            @(posedge sample_tick);
            act = {alu_signal, reg_file_write, main_mem_write, main_mem_read, branch_control,
                   immediate_select, oparand_1_select, oparand_2_select, reg_write_select};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: got %h with nothing expected", act);
            end else begin
                exp = exp_q.pop_front();
                ins = ins_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL decode ins=%h rst=%0b: got %h expected %h", ins, RESET, act, exp);
                end
            end
        end
    end

    initial begin
        logic [6:0]  opc_tbl[11];
        logic [6:0]  f7_tbl[4];
        logic [31:0] ins;
        logic [6:0]  opc, f7;
        logic        rst;
        int          wait_cycles;

        opc_tbl = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f, 7'h73};
        f7_tbl  = '{7'h00, 7'h20, 7'h01, 7'h00};
        checks = 0;
        errors = 0;
        sample_tick = 1'b0;
        RESET = 1'b1;
        INSTRUCTION = 32'h002081B3;

        // reset holds every output at zero
        drive(32'h002081B3, 1'b1, '0, 1'b1);

        // directed words with hand-derived expectations
        drive(32'h002081B3, 1'b0, pack(0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        drive(32'h402081B3, 1'b0, pack(8, 1, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        drive(32'h022081B3, 1'b0, pack(16, 1, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        drive(32'h00812283, 1'b0, pack(0, 1, 0, 10, 0, 1, 0, 1, 1), 1'b1);
        drive(32'h00512423, 1'b0, pack(0, 0, 6, 0, 0, 2, 0, 1, 0), 1'b1);
        drive(32'h00208863, 1'b0, pack(0, 0, 0, 0, 8, 3, 1, 1, 0), 1'b1);
        drive(32'h008000EF, 1'b0, pack(0, 1, 0, 0, 10, 5, 1, 1, 2), 1'b1);
        drive(32'h000080E7, 1'b0, pack(0, 1, 0, 0, 10, 1, 0, 1, 2), 1'b1);
        drive(32'h123452B7, 1'b0, pack(15, 1, 0, 0, 0, 4, 0, 1, 0), 1'b1);
        drive(32'h00000000, 1'b0, '0, 1'b1);
        drive(32'h0000000F, 1'b0, '0, 1'b1);
        drive(32'h00000073, 1'b0, '0, 1'b1);
        // illegal funct7 on OP, SUB-style funct7 with funct3 XOR, SRAI, AUIPC
        drive(32'h7E2081B3, 1'b0, '0, 1'b1);
        drive(32'h4020C1B3, 1'b0, '0, 1'b1);
        drive(32'h4030D193, 1'b0, pack(13, 1, 0, 0, 0, 1, 0, 1, 0), 1'b1);
        drive(32'h00001197, 1'b0, pack(0, 1, 0, 0, 0, 4, 1, 1, 0), 1'b1);

        // asynchronous RESET between clock edges
        drive(32'h002081B3, 1'b0, pack(0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        drive(32'h002081B3, 1'b1, '0, 1'b0);
        drive(32'h002081B3, 1'b0, pack(0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0);

        // randomized instructions
        for (int i = 0; i < 500; i++) begin
            ins = $urandom;
            opc = ($urandom_range(0, 5) == 0) ? 7'($urandom) : opc_tbl[$urandom_range(0, 10)];
            f7  = ($urandom_range(0, 4) == 0) ? 7'($urandom) : f7_tbl[$urandom_range(0, 3)];
            ins[6:0]   = opc;
            ins[31:25] = f7;
            rst = ($urandom_range(0, 19) == 0);
            drive(ins, rst, model(ins, rst), 1'b1);
        end

        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 100) begin
            @(posedge CLK);
            wait_cycles++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
